// File: rtl/fir_pkg.sv
// fir_pkg: shared definitions for the FIR response checker.
//   - default filter geometry constants
//   - checker state enumeration
//   - coefficient extraction helper for packed coefficient vectors
package fir_pkg;

    localparam int ORDER_DEF    = 4;
    localparam int WORD_IN_DEF  = 4;
    localparam int WORD_OUT_DEF = 9;
    localparam int LATENCY_DEF  = 0;
    localparam int CNT_W_DEF    = 8;
    localparam logic [15:0] COEFFS_DEF = 16'h4321;

    // Widest packed coefficient vector the helper accepts.
    localparam int COEFF_VEC_W = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        CHECK  = 2'd2,
        FAIL   = 2'd3
    } chk_state_t;

    // Returns b_k = vec[k*w +: w], zero-extended to 32 bits.
    function automatic logic [31:0] coeff_at(input logic [COEFF_VEC_W-1:0] vec,
                                             input int k,
                                             input int w);
        logic [31:0] mask;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return 32'(vec >> (k * w)) & mask;
    endfunction

endpackage

// File: rtl/fir_ref_model.sv
// fir_ref_model: reference FIR used by the response checker.
//   Keeps its own sample history, forms E = sum(b_k * hist[k]) modulo
//   2^word_size_out, and delays it by `latency` registers to give E_d.
// Ports:
//   clock    in   rising-edge clock
//   reset    in   synchronous active-high reset (clears history and delay line)
//   data_in  in   sample stream feeding the filter under check
//   expected out  E_d, the expected filter output for the current compare edge
module fir_ref_model
    import fir_pkg::*;
#(
    parameter int order         = ORDER_DEF,
    parameter int word_size_in  = WORD_IN_DEF,
    parameter int word_size_out = WORD_OUT_DEF,
    parameter logic [order*word_size_in-1:0] coeffs = COEFFS_DEF,
    parameter int latency       = LATENCY_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [word_size_in-1:0]  data_in,
    output logic [word_size_out-1:0] expected
);

    logic [word_size_in-1:0]  hist_r [order];
    logic [word_size_out-1:0] mac_s;

    // Sample history shift register, advancing every edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < order; k++) begin
                hist_r[k] <= {word_size_in{1'b0}};
            end
        end else begin
            hist_r[0] <= data_in;
            for (int k = 1; k < order; k++) begin
                hist_r[k] <= hist_r[k-1];
            end
        end
    end

    // Multiply-accumulate. Summing modulo 2^word_size_out gives the same
    // result as truncating the full-precision sum, so the accumulator is
    // only as wide as the filter output register.
    always_comb begin
        mac_s = {word_size_out{1'b0}};
        for (int k = 0; k < order; k++) begin
            mac_s = mac_s + word_size_out'(
                coeff_at(COEFF_VEC_W'(coeffs), k, word_size_in) * 32'(hist_r[k]));
        end
    end

    generate
        if (latency == 0) begin : g_no_delay
            assign expected = mac_s;
        end else begin : g_delay
            logic [word_size_out-1:0] dly_r [latency];

            // Delay line matching the filter's output pipeline depth.
            always_ff @(posedge clock) begin
                if (reset) begin
                    for (int j = 0; j < latency; j++) begin
                        dly_r[j] <= {word_size_out{1'b0}};
                    end
                end else begin
                    dly_r[0] <= mac_s;
                    for (int j = 1; j < latency; j++) begin
                        dly_r[j] <= dly_r[j-1];
                    end
                end
            end

            assign expected = dly_r[latency-1];
        end
    endgenerate

endmodule

// File: rtl/fir_response_checker.sv
// fir_response_checker: compares a FIR filter's Data_out against an
// internally rebuilt expected value and records the outcome.
// Ports:
//   clock          in   rising-edge clock
//   reset          in   synchronous active-high reset, shared with the filter
//   check_en       in   enables checking (IDLE -> WARMUP -> CHECK)
//   Data_in        in   sample stream driven to the filter
//   Data_out       in   filter output under check
//   pass           out  in CHECK, at least one compare done, never a mismatch
//   fail           out  sticky: at least one mismatch since reset
//   mismatch_count out  saturating mismatch counter
//   err_expected   out  expected value captured at the first mismatch
//   err_actual     out  Data_out captured at the first mismatch
module fir_response_checker
    import fir_pkg::*;
#(
    parameter int order         = ORDER_DEF,
    parameter int word_size_in  = WORD_IN_DEF,
    parameter int word_size_out = WORD_OUT_DEF,
    parameter logic [order*word_size_in-1:0] coeffs = COEFFS_DEF,
    parameter int latency       = LATENCY_DEF,
    parameter int cnt_width     = CNT_W_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     check_en,
    input  logic [word_size_in-1:0]  Data_in,
    input  logic [word_size_out-1:0] Data_out,
    output logic                     pass,
    output logic                     fail,
    output logic [cnt_width-1:0]     mismatch_count,
    output logic [word_size_out-1:0] err_expected,
    output logic [word_size_out-1:0] err_actual
);

    // Warmup lets the history and delay line fill with post-enable data.
    localparam int WARM   = order + latency;
    localparam int WARM_W = (WARM > 1) ? $clog2(WARM) : 1;
    localparam logic [WARM_W-1:0]    WARM_LAST = WARM_W'(WARM - 1);
    localparam logic [cnt_width-1:0] CNT_MAX   = {cnt_width{1'b1}};

    chk_state_t                 state_r, state_s;
    logic [WARM_W-1:0]          warm_cnt_r, warm_cnt_s;
    logic [word_size_out-1:0]   expected_d_s;
    logic                       do_compare_s, mismatch_s;
    logic                       pass_s, fail_s;
    logic [cnt_width-1:0]       count_s;
    logic [word_size_out-1:0]   err_exp_s, err_act_s;

    fir_ref_model #(
        .order         (order),
        .word_size_in  (word_size_in),
        .word_size_out (word_size_out),
        .coeffs        (coeffs),
        .latency       (latency)
    ) u_ref (
        .clock    (clock),
        .reset    (reset),
        .data_in  (Data_in),
        .expected (expected_d_s)
    );

    // Next-state, compare, counter and capture logic.
    always_comb begin
        state_s    = state_r;
        warm_cnt_s = {WARM_W{1'b0}};
        count_s    = mismatch_count;
        err_exp_s  = err_expected;
        err_act_s  = err_actual;

        // Compares run in CHECK and FAIL even on the edge check_en falls.
        do_compare_s = (state_r == CHECK) || (state_r == FAIL);
        mismatch_s   = do_compare_s && (Data_out != expected_d_s);

        case (state_r)
            IDLE: begin
                if (check_en) begin
                    state_s = WARMUP;
                end else begin
                    state_s = IDLE;
                end
            end
            WARMUP: begin
                if (!check_en) begin
                    state_s = IDLE;
                end else if (warm_cnt_r == WARM_LAST) begin
                    state_s = CHECK;
                end else begin
                    warm_cnt_s = warm_cnt_r + {{(WARM_W-1){1'b0}}, 1'b1};
                end
            end
            CHECK: begin
                if (!check_en) begin
                    state_s = IDLE;
                end else if (mismatch_s) begin
                    state_s = FAIL;
                end else begin
                    state_s = CHECK;
                end
            end
            FAIL: begin
                if (!check_en) begin
                    state_s = IDLE;
                end else begin
                    state_s = FAIL;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        if (mismatch_s && (mismatch_count != CNT_MAX)) begin
            count_s = mismatch_count + {{(cnt_width-1){1'b0}}, 1'b1};
        end else begin
            count_s = mismatch_count;
        end

        // Only the first mismatch since reset is captured.
        if (mismatch_s && !fail) begin
            err_exp_s = expected_d_s;
            err_act_s = Data_out;
        end else begin
            err_exp_s = err_expected;
            err_act_s = err_actual;
        end

        fail_s = fail | mismatch_s;
        pass_s = (state_s == CHECK) && (pass || do_compare_s) && !fail_s;
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r        <= IDLE;
            warm_cnt_r     <= {WARM_W{1'b0}};
            pass           <= 1'b0;
            fail           <= 1'b0;
            mismatch_count <= {cnt_width{1'b0}};
            err_expected   <= {word_size_out{1'b0}};
            err_actual     <= {word_size_out{1'b0}};
        end else begin
            state_r        <= state_s;
            warm_cnt_r     <= warm_cnt_s;
            pass           <= pass_s;
            fail           <= fail_s;
            mismatch_count <= count_s;
            err_expected   <= err_exp_s;
            err_actual     <= err_act_s;
        end
    end

endmodule

// File: doc/fir_response_checker.md
# fir_response_checker

Synthesizable on-chip response checker for the FIR filter datapath. It taps the same `Data_in` stream the filter consumes and the filter's `Data_out`, and rebuilds the expected output from its own sample history and coefficient set. Each cycle it compares expected against actual and latches the result into sticky pass/fail flags, a saturating mismatch counter and a first-error capture. It sits beside the filter as the reading end of the filter's sample interface, and lets a bench or FPGA build self-check without a software model.

## Interface
- `order`, default 4: number of taps, b0..b(order-1).
- `word_size_in`, default 4: sample and coefficient width (unsigned).
- `word_size_out`, default 9: filter output width (`2*word_size_in+1`).
- `coeffs`, default 16'h4321: packed coefficients; b_k = `coeffs[k*word_size_in +: word_size_in]`, giving b0=1, b1=2, b2=3, b3=4.
- `latency`, default 0: DUT output delay in cycles relative to its sample registers.
- `cnt_width`, default 8: mismatch counter width.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high; shared with the filter.
- `check_en`  in  1  enables comparison.
- `Data_in`  in  word_size_in  sample driven to the filter.
- `Data_out`  in  word_size_out  filter output under check.
- `pass`  out  1  in CHECK state, at least one compare done, no mismatch ever.
- `fail`  out  1  sticky, at least one mismatch.
- `mismatch_count`  out  cnt_width  saturating mismatch count.
- `err_expected`  out  word_size_out  expected value at the first mismatch.
- `err_actual`  out  word_size_out  `Data_out` at the first mismatch.

## Operation
- History register hist[0..order-1] shifts on every edge regardless of `check_en`:
  - hist[0] ← `Data_in`.
  - hist[k] ← hist[k-1].
  - `reset` zeroes all entries.
- Expected value E = Σ b_k·hist[k], computed at full precision and then truncated modulo 2^word_size_out, matching the DUT's register width.
  - E passes through `latency` registers, all zeroed by reset.
  - The delayed value is E_d.
- State machine:
  - IDLE → WARMUP on `check_en`=1.
  - WARMUP counts `order+latency` cycles → CHECK.
  - CHECK → FAIL on the first mismatch.
  - CHECK or FAIL → IDLE on `check_en`=0.
  - FAIL → WARMUP is not allowed; FAIL leaves only via IDLE or reset.
- Compare happens in CHECK and FAIL only, on every edge: mismatch when `Data_out` != E_d.
- First mismatch:
  - Loads `err_expected`/`err_actual`.
  - These hold until reset; later mismatches do not overwrite them.
- `mismatch_count` increments per mismatch and saturates at 2^cnt_width-1.
- Deasserting `check_en`:
  - Holds `fail`, counter and captures (not cleared).
  - `pass` drops to 0.
  - Re-enabling re-enters WARMUP.
- `reset` mid-operation:
  - Returns to IDLE.
  - Clears history, delay line, counters, flags and captures in that same edge.

## Timing
- Reset values:
  - `pass`=0, `fail`=0, `mismatch_count`=0.
  - `err_expected`=0, `err_actual`=0.
  - State IDLE.
- Compare alignment: `Data_out` sampled at edge t is checked against E from the hist contents present before edge t-`latency`.
  - With `latency`=0 this is the current, pre-edge history.
- All outputs are registered. A mismatch sampled at edge t shows on `fail`/`mismatch_count` after edge t, with zero extra cycles.
- `pass` rises after the first compare edge in CHECK.
- Mismatch and `check_en` falling on the same edge: the mismatch is counted, then the state goes to IDLE.
- Reset wins over all other events on the same edge.

## Structure
- Shared package `fir_pkg`:
  - Default `order`/word-size constants.
  - Coefficient-extraction function.
  - State enumeration {IDLE, WARMUP, CHECK, FAIL}.
- One sub-module, `fir_ref_model`: history register plus truncated MAC plus latency delay line, producing E_d.
- The top level holds the FSM, compare, counter and capture.

## Test plan
- Reset, then `check_en`=1 and `Data_in`=6 held, correct DUT → after warmup `Data_out`=60 matches; `pass`=1, `fail`=0, count 0.
- Sequence 6,3,2,5 with a correct DUT, then inject `Data_out`+1 for one cycle → next cycle `fail`=1, `pass`=0, count 1, `err_actual`=`err_expected`+1; a later mismatch leaves the captures unchanged.
- Persistent mismatch for 300 cycles → count saturates at 255, `fail` stays 1.
- Reset pulse mid-CHECK after a failure → all outputs 0, state IDLE; stream 2,0,2,4 re-checks clean with `pass`=1.
- Override `coeffs`=16'hFFFF, `Data_in`=15 held → expected 900 mod 512 = 388; a DUT presenting 388 passes.
- `check_en` dropped during an injected mismatch, then restored → count retained, `pass`=0, WARMUP repeats before any compare; `latency`=2 variant aligns with a 2-cycle-delayed DUT.
